// File: rtl/sw_buffer.sv
// sw_buffer: two-entry store buffer between the memory stage and data memory.
// Stores are lane-encoded, queued in program order and drained on mem_ready.
module sw_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic [5:0]  opM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  output logic        stallM,
  output logic        adesM,
  output logic [31:0] badaddrM,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  output logic        empty
);

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [29:0] addr_q [2];
  logic [3:0]  wen_q  [2];
  logic [31:0] data_q [2];

  logic        is_sb, is_sh, is_sw, is_store;
  logic        req_ok, enq, deq;
  logic [3:0]  wen_n;
  logic [31:0] wdata_n;

  assign is_sb    = (opM == OP_SB);
  assign is_sh    = (opM == OP_SH);
  assign is_sw    = (opM == OP_SW);
  assign is_store = is_sb | is_sh | is_sw;

  assign adesM    = validM & ((is_sh & aluoutM[0]) |
                              (is_sw & (aluoutM[1:0] != 2'b00)));
  assign badaddrM = adesM ? aluoutM : 32'h0;

  assign req_ok = validM & is_store & ~adesM & ~flushM;
  assign enq    = req_ok & (state_q != S_FULL);
  assign stallM = req_ok & (state_q == S_FULL);

  assign mem_req   = (state_q != S_EMPTY);
  assign deq       = mem_req & mem_ready;
  assign empty     = (state_q == S_EMPTY);
  assign mem_addr  = mem_req ? {addr_q[head_q], 2'b00} : 32'h0;
  assign mem_wen   = mem_req ? wen_q[head_q] : 4'b0000;
  assign mem_wdata = mem_req ? data_q[head_q] : 32'h0;

  // Byte-lane enables and replicated write data for the incoming store
  always_comb begin
    wen_n   = 4'b0000;
    wdata_n = writedataM;
    unique case (1'b1)
      is_sb: begin
        wen_n   = 4'b0001 << aluoutM[1:0];
        wdata_n = {4{writedataM[7:0]}};
      end
      is_sh: begin
        wen_n   = aluoutM[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{writedataM[15:0]}};
      end
      is_sw: begin
        wen_n   = 4'b1111;
        wdata_n = writedataM;
      end
      default: begin
        wen_n   = 4'b0000;
        wdata_n = writedataM;
      end
    endcase
  end

  // Occupancy next state and pointer advance
  always_comb begin
    state_d = state_q;
    head_d  = head_q ^ deq;
    tail_d  = tail_q ^ enq;
    unique case (state_q)
      S_EMPTY: if (enq) state_d = S_ONE;
      S_ONE: begin
        if (enq & ~deq)      state_d = S_FULL;
        else if (deq & ~enq) state_d = S_EMPTY;
      end
      S_FULL:  if (deq) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // State, pointers and entry storage; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= 30'h0;
        wen_q[i]  <= 4'b0000;
        data_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (enq) begin
        addr_q[tail_q] <= aluoutM[31:2];
        wen_q[tail_q]  <= wen_n;
        data_q[tail_q] <= wdata_n;
      end
    end
  end

endmodule

// File: tb/tb_sw_buffer.sv
// tb_sw_buffer: directed stimulus with a write scoreboard for sw_buffer.
// Expected memory writes are queued at issue and popped on each handshake.
module tb_sw_buffer;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LW = 6'b100011;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM;
  logic [5:0]  opM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        flushM;
  logic        stallM;
  logic        adesM;
  logic [31:0] badaddrM;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        empty;

  int  total = 0;
  int  bad   = 0;
  wr_t expq[$];

  sw_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .validM     (validM),
    .opM        (opM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .stallM     (stallM),
    .adesM      (adesM),
    .badaddrM   (badaddrM),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] op,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic f);
    validM     = v;
    opM        = op;
    aluoutM    = a;
    writedataM = d;
    flushM     = f;
  endtask

  task automatic idle();
    drv(1'b0, 6'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.w = w;
    e.d = d;
    expq.push_back(e);
  endtask

  // Monitor: every accepted write must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h wen %b data %h",
                 mem_addr, mem_wen, mem_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_wen", {28'h0, mem_wen}, {28'h0, e.w});
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_wen", {28'h0, mem_wen}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    tick();
    rst = 1'b0;

    // SB into top byte lane, drained immediately
    mem_ready = 1'b1;
    drv(1'b1, OP_SB, 32'h1003, 32'h000000A5, 1'b0);
    push(32'h1000, 4'b1000, 32'hA5A5A5A5);
    @(negedge clk);
    chk("sb_ades", {31'h0, adesM}, 32'h0);
    chk("sb_stall", {31'h0, stallM}, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("sb_req", {31'h0, mem_req}, 32'h1);
    tick();
    @(negedge clk);
    chk("sb_empty", {31'h0, empty}, 32'h1);

    // SH upper half, then misaligned SH faults
    tick();
    drv(1'b1, OP_SH, 32'h2002, 32'h1234BEEF, 1'b0);
    push(32'h2000, 4'b1100, 32'hBEEFBEEF);
    tick();
    drv(1'b1, OP_SH, 32'h2001, 32'h1234BEEF, 1'b0);
    @(negedge clk);
    chk("sh_ades", {31'h0, adesM}, 32'h1);
    chk("sh_bad", badaddrM, 32'h2001);
    chk("sh_stall", {31'h0, stallM}, 32'h0);
    tick();
    drv(1'b1, OP_SW, 32'h3002, 32'h0, 1'b0);
    @(negedge clk);
    chk("sw_ades", {31'h0, adesM}, 32'h1);
    chk("sw_bad", badaddrM, 32'h3002);
    tick();
    drv(1'b1, OP_LW, 32'h3003, 32'h0, 1'b0);
    @(negedge clk);
    chk("lw_ades", {31'h0, adesM}, 32'h0);
    chk("lw_bad", badaddrM, 32'h0);
    tick();
    drv(1'b1, OP_SB, 32'h3001, 32'hCAFE0077, 1'b0);
    push(32'h3000, 4'b0010, 32'h77777777);
    tick();
    drv(1'b1, OP_SH, 32'h3000, 32'hCAFE5566, 1'b0);
    push(32'h3000, 4'b0011, 32'h55665566);
    tick();
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("mix_empty", {31'h0, empty}, 32'h1);

    // Back-to-back SW with memory blocked: third stalls
    tick();
    mem_ready = 1'b0;
    drv(1'b1, OP_SW, 32'h10, 32'h11111111, 1'b0);
    push(32'h10, 4'b1111, 32'h11111111);
    tick();
    drv(1'b1, OP_SW, 32'h14, 32'h22222222, 1'b0);
    push(32'h14, 4'b1111, 32'h22222222);
    tick();
    drv(1'b1, OP_SW, 32'h18, 32'h33333333, 1'b0);
    push(32'h18, 4'b1111, 32'h33333333);
    @(negedge clk);
    chk("full_stall", {31'h0, stallM}, 32'h1);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("full_deq_stall", {31'h0, stallM}, 32'h1);
    tick();
    @(negedge clk);
    chk("retry_stall", {31'h0, stallM}, 32'h0);
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("b2b_empty", {31'h0, empty}, 32'h1);

    // FULL with deq: refused, accepted next cycle, ends FULL
    tick();
    mem_ready = 1'b0;
    drv(1'b1, OP_SW, 32'h40, 32'h44440000, 1'b0);
    push(32'h40, 4'b1111, 32'h44440000);
    tick();
    drv(1'b1, OP_SW, 32'h44, 32'h44440004, 1'b0);
    push(32'h44, 4'b1111, 32'h44440004);
    tick();
    mem_ready = 1'b1;
    drv(1'b1, OP_SW, 32'h48, 32'h44440008, 1'b0);
    push(32'h48, 4'b1111, 32'h44440008);
    @(negedge clk);
    chk("refuse_stall", {31'h0, stallM}, 32'h1);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("accept_stall", {31'h0, stallM}, 32'h0);
    tick();
    drv(1'b1, OP_SW, 32'h4C, 32'h0, 1'b0);
    @(negedge clk);
    chk("ends_full", {31'h0, stallM}, 32'h1);
    tick();
    idle();
    mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("refuse_empty", {31'h0, empty}, 32'h1);

    // Flushed SW is dropped; buffered entry still drains
    tick();
    mem_ready = 1'b0;
    drv(1'b1, OP_SW, 32'h50, 32'h55555555, 1'b0);
    push(32'h50, 4'b1111, 32'h55555555);
    tick();
    drv(1'b1, OP_SW, 32'h54, 32'h66666666, 1'b1);
    @(negedge clk);
    chk("flush_stall", {31'h0, stallM}, 32'h0);
    tick();
    idle();
    mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("flush_empty", {31'h0, empty}, 32'h1);

    // Reset while FULL and blocked abandons both entries
    tick();
    mem_ready = 1'b0;
    drv(1'b1, OP_SW, 32'h60, 32'h77777777, 1'b0);
    tick();
    drv(1'b1, OP_SW, 32'h64, 32'h88888888, 1'b0);
    tick();
    drv(1'b0, OP_SH, 32'h61, 32'h0, 1'b0);
    @(negedge clk);
    chk("nv_stall", {31'h0, stallM}, 32'h0);
    chk("nv_ades", {31'h0, adesM}, 32'h0);
    chk("nv_bad", badaddrM, 32'h0);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_req", {31'h0, mem_req}, 32'h0);
    chk("rst2_wen", {28'h0, mem_wen}, 32'h0);
    chk("rst2_empty", {31'h0, empty}, 32'h1);
    mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("leftover_exp", expq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
